rsa_modexp_cios: RTL and testbench

Next-generation RSA modular-exponentiation engine: computes C = M^E mod N for operands of arbitrary width WIDTH. Montgomery multiplication is performed word-serially (CIOS, radix 2^WORD), so multiplier area scales with WIDTH×WORD rather than WIDTH×WIDTH. The engine adds a start/busy/done handshake, leading-zero exponent skipping, an E = 0 shortcut, and an even-modulus error flag. It sits behind the SoC bus register block as the RSA accelerator datapath.

---
 rtl/rsa_modexp_cios.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_rsa_modexp_cios.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_cios.sv
// rsa_modexp_cios -- RSA modular exponentiation engine, C = M^E mod N.
//
// Left-to-right square-and-multiply over a word-serial CIOS Montgomery
// multiplier (radix 2^WORD). The leading zeros of the exponent are skipped,
// E = 0 and even N are answered without any Montgomery operation.
//
// Ports (rsa_modexp_cios):
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start_i        one-cycle request, sampled only while idle
//   m_i            message (< N)
//   e_i            exponent
//   n_i            modulus (odd, >= 3)
//   n0_inv_i       -N^-1 mod 2^WORD
//   r2_mod_n_i     R^2 mod N, R = 2^WIDTH
//   c_o            result, held until the next done
//   busy_o         high from the cycle after an accepted start until done
//   done_o         one-cycle pulse when c_o is valid
//   err_o          set with done when N is even, cleared on the next start
//
// Ports (rsa_mm_cios, internal):
//   start_i        load operands and begin one MontMul
//   a_i, b_i       operands (< N)
//   n_i, n0_inv_i  modulus and its negated inverse mod 2^WORD
//   done_o         high during the final (conditional subtract) cycle
//   res_o          A*B*R^-1 mod N, valid while done_o is high

module rsa_mm_cios #(
  parameter int WIDTH = 64,
  parameter int WORD  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  input  logic [WORD-1:0]  n0_inv_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o
);
  localparam int S  = WIDTH / WORD;
  localparam int TW = WIDTH + WORD + 2;
  localparam int CW = $clog2(S + 1);

  typedef enum logic [1:0] {E_IDLE, E_A, E_B, E_FIN} est_t;

  est_t             st_q, st_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [TW-1:0]    t_q, t_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH+WORD-1:0] prod_ab;
  logic [WIDTH+WORD-1:0] prod_mn;
  logic [WORD-1:0]       m_word;
  logic [TW-1:0]         t_red;
  logic                  t_ge_n;

  // a_q is consumed from its low limb; it shifts down one limb per iteration.
  assign prod_ab = {{WIDTH{1'b0}}, a_q[WORD-1:0]} * {{WORD{1'b0}}, b_q};
  assign m_word  = t_q[WORD-1:0] * n0_inv_i;
  assign prod_mn = {{WIDTH{1'b0}}, m_word} * {{WORD{1'b0}}, n_i};
  assign t_red   = t_q + {2'b00, prod_mn};

  // T < 2N at the end, so T - N fits in WIDTH bits and the low slice suffices.
  assign t_ge_n = (t_q >= {{(WORD + 2){1'b0}}, n_i});
  assign res_o  = t_ge_n ? (t_q[WIDTH-1:0] - n_i) : t_q[WIDTH-1:0];
  assign done_o = (st_q == E_FIN);

  always_comb begin
    st_d  = st_q;
    a_d   = a_q;
    b_d   = b_q;
    t_d   = t_q;
    cnt_d = cnt_q;
    unique case (st_q)
      E_IDLE: begin
        if (start_i) begin
          a_d   = a_i;
          b_d   = b_i;
          t_d   = '0;
          cnt_d = CW'(S - 1);
          st_d  = E_A;
        end
      end
      E_A: begin
        t_d  = t_q + {2'b00, prod_ab};
        st_d = E_B;
      end
      E_B: begin
        t_d   = t_red >> WORD;
        a_d   = a_q >> WORD;
        cnt_d = cnt_q - 1'b1;
        st_d  = (cnt_q == '0) ? E_FIN : E_A;
      end
      E_FIN: st_d = E_IDLE;
      default: st_d = E_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= E_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      t_q   <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      a_q   <= a_d;
      b_q   <= b_d;
      t_q   <= t_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// Top-level sequencer.
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | waiting for start; operands captured on acceptance
//   CHECK    | even-N / E=0 shortcuts, or skip SCAN when E[MSB] is set
//   SCAN     | shift E left one bit per cycle until its MSB is 1
//   MM_START | dispatch one MontMul for the operation in op_q
//   MM_WAIT  | wait for the MontMul result, pick the next operation
//   FINISH   | publish C/err and pulse done
module rsa_modexp_cios #(
  parameter int WIDTH  = 64,
  parameter int WORD   = 32,
  parameter int E_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  m_i,
  input  logic [E_BITS-1:0] e_i,
  input  logic [WIDTH-1:0]  n_i,
  input  logic [WORD-1:0]   n0_inv_i,
  input  logic [WIDTH-1:0]  r2_mod_n_i,
  output logic [WIDTH-1:0]  c_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int BW = (E_BITS > 1) ? $clog2(E_BITS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SCAN, S_MM_START, S_MM_WAIT, S_FINISH} state_t;
  typedef enum logic [1:0] {OP_TOMONT, OP_SQR, OP_MUL, OP_FROM} op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [WIDTH-1:0]  m_q, m_d;
  logic [E_BITS-1:0] e_q, e_d;
  logic [WIDTH-1:0]  n_q, n_d;
  logic [WORD-1:0]   n0_q, n0_d;
  logic [WIDTH-1:0]  r2_q, r2_d;
  logic [WIDTH-1:0]  mbar_q, mbar_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [WIDTH-1:0]  c_q, c_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic             mm_start;
  logic             mm_done;
  logic [WIDTH-1:0] mm_a, mm_b, mm_res;
  logic             advance;

  assign mm_start = (state_q == S_MM_START);

  always_comb begin
    mm_a = res_q;
    mm_b = res_q;
    unique case (op_q)
      OP_TOMONT: begin
        mm_a = m_q;
        mm_b = r2_q;
      end
      OP_MUL:  mm_b = mbar_q;
      OP_FROM: mm_b = WIDTH'(1);
      default: ;
    endcase
  end

  rsa_mm_cios #(.WIDTH(WIDTH), .WORD(WORD)) u_mm (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mm_start),
    .a_i      (mm_a),
    .b_i      (mm_b),
    .n_i      (n_q),
    .n0_inv_i (n0_q),
    .done_o   (mm_done),
    .res_o    (mm_res)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    m_d     = m_q;
    e_d     = e_q;
    n_d     = n_q;
    n0_d    = n0_q;
    r2_d    = r2_q;
    mbar_d  = mbar_q;
    res_d   = res_q;
    bits_d  = bits_q;
    c_d     = c_q;
    err_d   = err_q;
    done_d  = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          m_d     = m_i;
          e_d     = e_i;
          n_d     = n_i;
          n0_d    = n0_inv_i;
          r2_d    = r2_mod_n_i;
          bits_d  = BW'(E_BITS - 1);
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!n_q[0]) begin
          res_d   = '0;
          state_d = S_FINISH;
        end else if (e_q == '0) begin
          res_d   = WIDTH'(1);
          state_d = S_FINISH;
        end else if (e_q[E_BITS-1]) begin
          op_d    = OP_TOMONT;
          state_d = S_MM_START;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Leave on the shift that brings the leading one into the MSB.
        e_d    = e_q << 1;
        bits_d = bits_q - 1'b1;
        if (e_q[E_BITS-2]) begin
          op_d    = OP_TOMONT;
          state_d = S_MM_START;
        end
      end
      S_MM_START: state_d = S_MM_WAIT;
      S_MM_WAIT: begin
        if (mm_done) begin
          res_d   = mm_res;
          state_d = S_MM_START;
          unique case (op_q)
            OP_TOMONT: begin
              mbar_d  = mm_res;
              advance = 1'b1;
            end
            OP_SQR: begin
              if (e_q[E_BITS-1]) op_d = OP_MUL;
              else               advance = 1'b1;
            end
            OP_MUL:  advance = 1'b1;
            OP_FROM: state_d = S_FINISH;
            default: state_d = S_FINISH;
          endcase
          // bits_q counts exponent bits still below the one just finished.
          if (advance) begin
            if (bits_q == '0) begin
              op_d = OP_FROM;
            end else begin
              e_d    = e_q << 1;
              bits_d = bits_q - 1'b1;
              op_d   = OP_SQR;
            end
          end
        end
      end
      S_FINISH: begin
        c_d     = res_q;
        err_d   = ~n_q[0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_TOMONT;
      m_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      n0_q    <= '0;
      r2_q    <= '0;
      mbar_q  <= '0;
      res_q   <= '0;
      bits_q  <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      m_q     <= m_d;
      e_q     <= e_d;
      n_q     <= n_d;
      n0_q    <= n0_d;
      r2_q    <= r2_d;
      mbar_q  <= mbar_d;
      res_q   <= res_d;
      bits_q  <= bits_d;
      c_q     <= c_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign c_o    = c_q;
  assign err_o  = err_q;
  assign done_o = done_q;
  assign busy_o = (state_q != S_IDLE);
endmodule

// File: tb/tb_rsa_modexp_cios.sv
module tb_rsa_modexp_cios;
  localparam int WIDTH  = 64;
  localparam int WORD   = 32;
  localparam int E_BITS = 32;
  localparam int S      = WIDTH / WORD;
  localparam int P      = 2 * S + 1;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic [WIDTH-1:0]  m_i;
  logic [E_BITS-1:0] e_i;
  logic [WIDTH-1:0]  n_i;
  logic [WORD-1:0]   n0_inv_i;
  logic [WIDTH-1:0]  r2_mod_n_i;
  logic [WIDTH-1:0]  c_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  rsa_modexp_cios #(.WIDTH(WIDTH), .WORD(WORD), .E_BITS(E_BITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .m_i        (m_i),
    .e_i        (e_i),
    .n_i        (n_i),
    .n0_inv_i   (n0_inv_i),
    .r2_mod_n_i (r2_mod_n_i),
    .c_o        (c_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  typedef struct {
    logic [WIDTH-1:0] c;
    logic             err;
    int               acc_cyc;
    int               done_cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   busy_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Right-to-left binary exponentiation with plain modular arithmetic.
  function automatic logic [WIDTH-1:0] ref_modexp(input logic [WIDTH-1:0] m, input logic [E_BITS-1:0] e,
                                                  input logic [WIDTH-1:0] n);
    logic [2*WIDTH-1:0] r, b, nn;
    nn = {{WIDTH{1'b0}}, n};
    r  = 1;
    b  = {{WIDTH{1'b0}}, m} % nn;
    for (int i = 0; i < E_BITS; i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] calc_r2(input logic [WIDTH-1:0] n);
    logic [2*WIDTH-1:0] r, nn;
    nn = {{WIDTH{1'b0}}, n};
    r  = (128'd1 << WIDTH) % nn;
    r  = (r * r) % nn;
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [WORD-1:0] calc_n0(input logic [WIDTH-1:0] n);
    logic [WORD-1:0] x, nl;
    nl = n[WORD-1:0];
    x  = nl;
    repeat (5) x = x * (32'd2 - nl * x);
    return -x;
  endfunction

  function automatic int ref_latency(input logic [E_BITS-1:0] e, input logic [WIDTH-1:0] n);
    int h;
    if (!n[0] || e == '0) return 2;
    h = 0;
    for (int i = 0; i < E_BITS; i++) if (e[i]) h = i;
    return 2 + (E_BITS - 1 - h) + (h + ($countones(e) - 1) + 2) * (P + 1);
  endfunction

  // Called at a negedge; the next posedge accepts the request.
  task automatic issue(input logic [WIDTH-1:0] m, input logic [E_BITS-1:0] e, input logic [WIDTH-1:0] n);
    exp_t x;
    m_i        = m;
    e_i        = e;
    n_i        = n;
    n0_inv_i   = calc_n0(n);
    r2_mod_n_i = calc_r2(n);
    x.err      = ~n[0];
    x.c        = (!n[0]) ? '0 : ((e == '0) ? WIDTH'(1) : ref_modexp(m, e, n));
    x.acc_cyc  = cyc + 1;
    x.done_cyc = cyc + 1 + ref_latency(e, n);
    sbq.push_back(x);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done, %0d outstanding", sbq.size());
      sbq.delete();
    end
  endtask

  // Monitor / scoreboard.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (done_o) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
      end else begin
        x = sbq.pop_front();
        chk("result_c", c_o, x.c);
        chk("result_err", WIDTH'(err_o), WIDTH'(x.err));
        chk("done_latency", WIDTH'(cyc - x.acc_cyc), WIDTH'(x.done_cyc - x.acc_cyc));
        chk("busy_low_at_done", WIDTH'(busy_o), '0);
        chk("busy_during_run_drops", WIDTH'(busy_bad), '0);
      end
      busy_bad = 0;
    end else if (sbq.size() != 0 && cyc >= sbq[0].acc_cyc && !busy_o) begin
      busy_bad++;
    end
  end

  initial begin
    logic [WIDTH-1:0] rn, rm;
    logic [E_BITS-1:0] re;
    int guard;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    m_i        = '0;
    e_i        = '0;
    n_i        = '0;
    n0_inv_i   = '0;
    r2_mod_n_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_c", c_o, '0);
    chk("reset_done", WIDTH'(done_o), '0);
    chk("reset_busy", WIDTH'(busy_o), '0);
    chk("reset_err", WIDTH'(err_o), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Textbook RSA pair, then decryption with disturbances while busy.
    issue(64'd65, 32'd17, 64'd3233);
    wait_idle(1000);
    issue(64'd2790, 32'd2753, 64'd3233);
    repeat (20) @(negedge clk);
    m_i        = {$urandom, $urandom};
    e_i        = $urandom;
    n_i        = {$urandom, $urandom} | 64'd1;
    n0_inv_i   = $urandom;
    r2_mod_n_i = {$urandom, $urandom};
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle(1000);

    issue(64'd1234, 32'd0, 64'd3233);
    wait_idle(1000);
    issue(64'd0, 32'd1, 64'd3233);
    wait_idle(1000);
    issue(64'd3232, 32'hFFFF_FFFF, 64'd3233);
    wait_idle(1000);

    // Even modulus, then a valid run must clear err at acceptance.
    issue(64'd65, 32'd17, 64'd3232);
    wait_idle(1000);
    issue(64'd65, 32'd17, 64'd3233);
    chk("err_cleared_on_start", WIDTH'(err_o), '0);
    wait_idle(1000);

    // Reset in the middle of an exponentiation.
    issue(64'd65, 32'd17, 64'd3233);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_c", c_o, '0);
    chk("midrst_done", WIDTH'(done_o), '0);
    chk("midrst_busy", WIDTH'(busy_o), '0);
    chk("midrst_err", WIDTH'(err_o), '0);
    sbq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(64'd65, 32'd17, 64'd3233);
    wait_idle(1000);

    // Random 64-bit operands, each new start issued in the cycle done is high.
    for (int k = 0; k < 6; k++) begin
      rn = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
      rm = {$urandom, $urandom} % rn;
      re = (k % 2 == 0) ? $urandom : $urandom_range(2, 300);
      if (k > 0) begin
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!done_o && guard < 1000);
        if (!done_o) begin
          checks++;
          errors++;
          $display("FAIL chain_wait timeout at step %0d", k);
        end
      end
      issue(rm, re, rn);
    end
    wait_idle(1000);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
